// File: rtl/keylog_reader.sv
// keylog_reader: read end of the key log.
// Keyboard-side strobes push key codes into a circular buffer; the CPU drains
// them oldest-first through a one-cycle request/valid read port. Occupancy,
// full/empty and a sticky overflow flag are exposed for status polling.
//
// Build option: define KEYLOG_OVERWRITE_EN so that a push into a full buffer
// with no same-cycle read replaces the oldest entry. Left undefined, that push
// is dropped. Overflow is flagged in both builds.
//
// Ports:
//   clk       system clock, all state changes on posedge
//   reset     synchronous active-high reset
//   wr_en     key strobe, one entry pushed per cycle high
//   wr_data   key code to push
//   rd_req    CPU read request, one entry popped per cycle high
//   clear     synchronous flush of buffer and overflow flag
//   rd_data   registered read data
//   rd_valid  one-cycle pulse, rd_data carries a popped entry
//   empty     count == 0 (combinational)
//   full      count == DEPTH (combinational)
//   count     entries stored, 0..DEPTH
//   overflow  sticky, at least one push lost an entry
module keylog_reader #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_req,
    input  logic                  clear,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic             do_rd;     // pop an entry this cycle
    logic             wr_ok;     // push that finds (or frees) a slot
    logic             wr_lost;   // push into a full buffer with no read
    logic             mem_we;    // memory write strobe
    logic             rd_adv;    // read pointer advances
    logic [CW-1:0]    count_nxt;

    assign empty = (count == CW'(0));
    assign full  = (count == CW'(DEPTH));

    // Read/write qualification; a read on a full buffer frees the slot for a
    // same-cycle write.
    always_comb begin
        do_rd     = rd_req && !empty;
        wr_ok     = wr_en && (!full || do_rd);
        wr_lost   = wr_en && full && !rd_req;
`ifdef KEYLOG_OVERWRITE_EN
        // Overwrite the oldest entry: wr_ptr == rd_ptr when full, both advance.
        mem_we    = wr_ok || wr_lost;
        rd_adv    = do_rd || wr_lost;
`else
        mem_we    = wr_ok;
        rd_adv    = do_rd;
`endif
        count_nxt = count;
        if (wr_ok && !do_rd) begin
            count_nxt = count + CW'(1);
        end else if (do_rd && !wr_ok) begin
            count_nxt = count - CW'(1);
        end
    end

    // Control state and registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            // rd_data deliberately holds its last value across a flush.
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
            end
            if (mem_we) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_lost) begin
                overflow <= 1'b1;
            end
            count <= count_nxt;
        end
    end

    // Storage array, not reset.
    always_ff @(posedge clk) begin
        if (!reset && !clear && mem_we) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_keylog_reader.sv
// Self-checking bench for keylog_reader: directed vectors, expected read data
// queued at request time and matched by an independent rd_valid monitor.
module tb_keylog_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_req;
    logic       clear;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

`ifdef KEYLOG_OVERWRITE_EN
    localparam int OFS = 1;
`else
    localparam int OFS = 0;
`endif

    keylog_reader #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .clear    (clear),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Monitor: after every edge, any rd_valid pulse must match the oldest
    // outstanding expectation.
    always @(posedge clk) begin
        #2;
        if (rd_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rd_valid: got data %02h, nothing expected", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_fail++;
                    $display("FAIL rd_data: got %02h, expected %02h", rd_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic pop_expect(input logic [7:0] v);
        exp_q.push_back(v);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
    endtask

    task automatic drained(input string name);
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; rd_req = 1'b0; clear = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("reset_count", int'(count), 0);
        check("reset_empty", int'(empty), 1);
        check("reset_full", int'(full), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_rd_valid", int'(rd_valid), 0);

        // Read on empty after reset: no pulse, data stays zero.
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check("empty_rd_valid", int'(rd_valid), 0);
        check("empty_rd_data", int'(rd_data), 0);
        check("empty_count", int'(count), 0);

        // Basic ordering.
        push(8'h41); push(8'h42); push(8'h43);
        check("basic_count3", int'(count), 3);
        pop_expect(8'h41);
        check("basic_latency_valid", int'(rd_valid), 1);
        pop_expect(8'h42);
        pop_expect(8'h43);
        drained("basic_drained");
        check("basic_empty", int'(empty), 1);
        check("basic_count0", int'(count), 0);
        step();
        check("basic_valid_drops", int'(rd_valid), 0);

        // Overflow: 17 pushes into 16 slots.
        do_clear();
        for (int i = 0; i <= 16; i++) push(8'(i));
        check("ovf_full", int'(full), 1);
        check("ovf_count", int'(count), 16);
        check("ovf_flag", int'(overflow), 1);
        for (int i = 0; i < 16; i++) pop_expect(8'(i + OFS));
        drained("ovf_drained");
        check("ovf_empty_after", int'(empty), 1);
        check("ovf_sticky", int'(overflow), 1);

        // Pointer wrap.
        do_clear();
        for (int i = 0; i < 12; i++) push(8'(8'h50 + i));
        for (int i = 0; i < 12; i++) pop_expect(8'(8'h50 + i));
        for (int i = 0; i < 10; i++) push(8'(8'hA0 + i));
        check("wrap_count10", int'(count), 10);
        for (int i = 0; i < 10; i++) pop_expect(8'(8'hA0 + i));
        drained("wrap_drained");
        check("wrap_wr_ptr", int'(dut.wr_ptr), 6);
        check("wrap_rd_ptr", int'(dut.rd_ptr), 6);
        check("wrap_empty", int'(empty), 1);

        // Simultaneous write and read on a full buffer.
        do_clear();
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        check("fullrw_full_before", int'(full), 1);
        exp_q.push_back(8'h10);
        wr_en = 1'b1; wr_data = 8'h77; rd_req = 1'b1;
        step();
        wr_en = 1'b0; rd_req = 1'b0;
        drained("fullrw_oldest");
        check("fullrw_count", int'(count), 16);
        check("fullrw_overflow", int'(overflow), 0);
        for (int i = 1; i < 16; i++) pop_expect(8'(8'h10 + i));
        pop_expect(8'h77);
        drained("fullrw_drained");
        check("fullrw_empty", int'(empty), 1);

        // Clear beats a same-cycle write on a 5-entry overflowed buffer.
        do_clear();
        for (int i = 0; i <= 16; i++) push(8'(8'h20 + i));
        for (int i = 0; i < 11; i++) pop_expect(8'(8'h20 + i + OFS));
        drained("clr_pre_drained");
        check("clr_pre_count", int'(count), 5);
        check("clr_pre_overflow", int'(overflow), 1);
        clear = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
        step();
        clear = 1'b0; wr_en = 1'b0;
        check("clr_count", int'(count), 0);
        check("clr_empty", int'(empty), 1);
        check("clr_overflow", int'(overflow), 0);
        check("clr_rd_data_holds", int'(rd_data), 8'h20 + 10 + OFS);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check("clr_byte_discarded", int'(rd_valid), 0);

        // Reset during a read cycle.
        push(8'h99); push(8'h9A);
        pop_expect(8'h99);
        drained("rst_pre_read");
        reset = 1'b1; rd_req = 1'b1;
        step();
        reset = 1'b0; rd_req = 1'b0;
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        step();
        drained("final_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
